// File: rtl/elite_spi_7seg_rx.sv
// SPI mode-0 slave feeding the 7-segment display word; echoes the previous byte on MISO.
// SPI pins are oversampled in the CLOCK_50 domain through a synchronizer and edge detector.
module elite_spi_7seg_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic              CLOCK_50,
  input  logic              Reset_SPI,
  input  logic              SPI_SCLK,
  input  logic              SPI_CS_N,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              SPI_MISO_OE,
  output logic [DATA_W-1:0] Elite_7Seg_Disp_Word,
  output logic              Elite_7Seg_Set_Flag,
  output logic              SPI_Frame_Err
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] csSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic                   sclkPrev_q;
  logic                   csPrev_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-2:0]      rxShift_q;
  logic [DATA_W-1:0]      tx_q;
  logic [DATA_W-1:0]      dispWord_q;
  logic                   setFlag_q;
  logic                   frameErr_q;
  logic                   misoOe_q;
  logic                   byteDone_q;

  logic                   sclkS;
  logic                   csS;
  logic                   mosiS;
  logic                   sclkRise;
  logic                   sclkFall;
  logic                   csRise;
  logic                   csFall;
  logic [DATA_W-1:0]      rxByte_d;
  logic [CNT_W-1:0]       cntInc_d;

  // CS_N synchronizer resets to "selected" so a frame already in progress is never mistaken for a new one.
  always_ff @(posedge CLOCK_50) begin
    if (Reset_SPI) begin
      sclkSync_q <= '0;
      csSync_q   <= '0;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SPI_SCLK};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], SPI_CS_N};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sclkPrev_q <= sclkS;
      csPrev_q   <= csS;
    end
  end

  assign sclkS    = sclkSync_q[SYNC_STAGES-1];
  assign csS      = csSync_q[SYNC_STAGES-1];
  assign mosiS    = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  assign csRise   = csS & ~csPrev_q;
  assign csFall   = ~csS & csPrev_q;

  assign rxByte_d = {rxShift_q, mosiS};
  assign cntInc_d = cnt_q + 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (Reset_SPI) begin
      state_q    <= WAIT_IDLE;
      cnt_q      <= '0;
      rxShift_q  <= '0;
      tx_q       <= '0;
      dispWord_q <= '0;
      setFlag_q  <= 1'b0;
      frameErr_q <= 1'b0;
      misoOe_q   <= 1'b0;
      byteDone_q <= 1'b0;
    end else begin
      setFlag_q  <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        WAIT_IDLE: begin
          if (csS) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (csFall) begin
            tx_q       <= dispWord_q;
            cnt_q      <= '0;
            rxShift_q  <= '0;
            byteDone_q <= 1'b0;
            misoOe_q   <= 1'b1;
            state_q    <= ACTIVE;
          end
        end
        ACTIVE: begin
          // Deselect takes priority over a coincident SCLK edge.
          if (csRise) begin
            state_q    <= IDLE;
            misoOe_q   <= 1'b0;
            frameErr_q <= (cnt_q != '0);
            cnt_q      <= '0;
          end else if (sclkRise) begin
            rxShift_q <= rxByte_d[DATA_W-2:0];
            if (cnt_q == LAST_BIT) begin
              dispWord_q <= rxByte_d;
              setFlag_q  <= 1'b1;
              byteDone_q <= 1'b1;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cntInc_d;
            end
          end else if (sclkFall) begin
            if ((cnt_q == '0) && byteDone_q) begin
              tx_q <= dispWord_q;
            end else begin
              tx_q <= {tx_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: begin
          state_q <= WAIT_IDLE;
        end
      endcase
    end
  end

  assign SPI_MISO             = misoOe_q & tx_q[DATA_W-1];
  assign SPI_MISO_OE          = misoOe_q;
  assign Elite_7Seg_Disp_Word = dispWord_q;
  assign Elite_7Seg_Set_Flag  = setFlag_q;
  assign SPI_Frame_Err        = frameErr_q;

endmodule

// File: tb/tb_elite_spi_7seg_rx.sv
// Directed bench for elite_spi_7seg_rx: a bit-banged SPI master drives bytes while a
// scoreboard queue holds expected display words popped on every Set_Flag pulse.
module tb_elite_spi_7seg_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       csn;
  logic       mosi;
  logic       miso;
  logic       oe;
  logic [7:0] word;
  logic       flag;
  logic       ferr;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         riseCyc = 0;
  int         ferrCycles = 0;
  logic       flagPrev = 1'b0;
  logic [7:0] expQ[$];
  logic [7:0] expWord;

  elite_spi_7seg_rx #(
    .SYNC_STAGES(2),
    .DATA_W     (8)
  ) dut (
    .CLOCK_50            (clk),
    .Reset_SPI           (rst),
    .SPI_SCLK            (sclk),
    .SPI_CS_N            (csn),
    .SPI_MOSI            (mosi),
    .SPI_MISO            (miso),
    .SPI_MISO_OE         (oe),
    .Elite_7Seg_Disp_Word(word),
    .Elite_7Seg_Set_Flag (flag),
    .SPI_Frame_Err       (ferr)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard side: every Set_Flag pops one expected word and checks width and latency.
  always @(negedge clk) begin
    if (!rst) begin
      if (flag) begin
        checks++;
        assert (flagPrev === 1'b0) else begin
          errors++;
          $error("[TB] FAIL set_flag_width observed=multi-cycle expected=1 cycle");
        end
        checks++;
        assert (expQ.size() > 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_set_flag observed word=%h expected no flag", word);
        end
        if (expQ.size() > 0) begin
          expWord = expQ.pop_front();
          checks++;
          assert (word === expWord) else begin
            errors++;
            $error("[TB] FAIL disp_word observed=%h expected=%h", word, expWord);
          end
        end
        checks++;
        assert ((cyc - riseCyc) === 3) else begin
          errors++;
          $error("[TB] FAIL set_flag_latency observed=%0d expected=3", cyc - riseCyc);
        end
      end
      if (ferr) ferrCycles++;
    end
    flagPrev = flag;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shifts nBits of data MSB first; MISO is sampled just before each rising SCLK edge.
  task automatic applyStimulus(input logic [7:0] data, input int nBits, input bit capture,
                               input bit checkMiso, input logic [7:0] expMiso);
    logic [7:0] misoByte;
    misoByte = '0;
    for (int i = 0; i < nBits; i++) begin
      mosi = data[7-i];
      repeat (5) @(negedge clk);
      misoByte = {misoByte[6:0], miso};
      sclk = 1'b1;
      if (capture && (i == nBits - 1)) begin
        riseCyc = cyc;
        expQ.push_back(data);
      end
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    if (checkMiso) checkOutput("miso_byte", misoByte, expMiso);
  endtask

  task automatic csLow();
    csn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csHigh(input int gap);
    repeat (5) @(negedge clk);
    csn = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    csn  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_word", word, 8'h00);
    checkOutput("reset_flag", 8'(flag), 8'h00);
    checkOutput("reset_ferr", 8'(ferr), 8'h00);
    checkOutput("reset_miso", 8'(miso), 8'h00);
    checkOutput("reset_oe", 8'(oe), 8'h00);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("idle_oe", 8'(oe), 8'h00);

    $display("[TB] single byte 0xA5");
    csLow();
    checkOutput("active_oe", 8'(oe), 8'h01);
    applyStimulus(8'hA5, 8, 1'b1, 1'b1, 8'h00);
    csHigh(8);
    checkOutput("word_a5", word, 8'hA5);
    checkOutput("oe_after_frame", 8'(oe), 8'h00);

    $display("[TB] three-byte frame");
    csLow();
    applyStimulus(8'h3C, 8, 1'b1, 1'b1, 8'hA5);
    applyStimulus(8'hF0, 8, 1'b1, 1'b1, 8'h3C);
    applyStimulus(8'h81, 8, 1'b1, 1'b1, 8'hF0);
    csHigh(8);
    checkOutput("word_81", word, 8'h81);

    $display("[TB] aborted byte");
    csLow();
    applyStimulus(8'hFF, 5, 1'b0, 1'b0, 8'h00);
    csHigh(8);
    checkOutput("frame_err_cycles", 8'(ferrCycles), 8'h01);
    checkOutput("word_after_abort", word, 8'h81);
    csLow();
    applyStimulus(8'h12, 8, 1'b1, 1'b1, 8'h81);
    csHigh(8);
    checkOutput("word_12", word, 8'h12);

    $display("[TB] reset mid-byte");
    csLow();
    applyStimulus(8'hC3, 4, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midreset_word", word, 8'h00);
    checkOutput("midreset_oe", 8'(oe), 8'h00);
    rst = 1'b0;
    applyStimulus(8'hFF, 8, 1'b0, 1'b0, 8'h00);
    checkOutput("wait_idle_oe", 8'(oe), 8'h00);
    checkOutput("wait_idle_word", word, 8'h00);
    csHigh(8);
    csLow();
    applyStimulus(8'h5A, 8, 1'b1, 1'b1, 8'h00);
    csHigh(8);
    checkOutput("word_5a", word, 8'h5A);
    checkOutput("frame_err_after_reset", 8'(ferrCycles), 8'h01);

    $display("[TB] SCLK with CS_N high");
    applyStimulus(8'h77, 8, 1'b0, 1'b0, 8'h00);
    checkOutput("deselected_oe", 8'(oe), 8'h00);
    checkOutput("deselected_miso", 8'(miso), 8'h00);
    checkOutput("deselected_word", word, 8'h5A);

    $display("[TB] back-to-back frames");
    csLow();
    applyStimulus(8'h00, 8, 1'b1, 1'b1, 8'h5A);
    csHigh(4);
    csLow();
    applyStimulus(8'hFF, 8, 1'b1, 1'b1, 8'h00);
    csHigh(8);
    checkOutput("word_ff", word, 8'hFF);
    checkOutput("pending_flags", 8'(expQ.size()), 8'h00);
    checkOutput("frame_err_final", 8'(ferrCycles), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elite_spi_7seg_rx.md
Name: elite_spi_7seg_rx

Overview:
SPI mode-0 slave that deserializes bytes from the HPS/external SPI master into the 8-bit display word consumed by the 7-segment display block. Each completed byte produces a one-cycle set flag. It also returns the previously received byte on MISO so the master can perform loopback checks. All logic runs in the CLOCK_50 domain; SPI pins are oversampled through synchronizers.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizer on SCLK/CS_N/MOSI (min 2)
DATA_W, 8, bits per SPI byte and width of the display word

Ports:
CLOCK_50  input  1  system clock, 50 MHz
Reset_SPI  input  1  synchronous, active-high reset
SPI_SCLK  input  1  SPI clock from master, CPOL=0, async to CLOCK_50
SPI_CS_N  input  1  chip select, active low, async
SPI_MOSI  input  1  master-out data, MSB first
SPI_MISO  output  1  slave-out data, MSB first
SPI_MISO_OE  output  1  MISO output enable (1 while selected)
Elite_7Seg_Disp_Word  output  DATA_W  last completed received byte
Elite_7Seg_Set_Flag  output  1  one-cycle pulse when Disp_Word updates
SPI_Frame_Err  output  1  one-cycle pulse on CS_N deassert mid-byte

Behaviour:
- Reset values: Disp_Word=0x00, Set_Flag=0, Frame_Err=0, MISO=0, MISO_OE=0, bit counter=0, rx/tx shift regs=0x00, state=WAIT_IDLE.
- Inputs pass through SYNC_STAGES flops. Edge detection compares the last synchronized sample with the previous one, giving 1 extra stage.
- Constraint: SCLK high and low phases are each >=4 CLOCK_50 cycles (SCLK <= 6.25 MHz). Behaviour is undefined otherwise.
- FSM states:
  - WAIT_IDLE: entered from reset. All SCLK edges are ignored. Moves to IDLE once synced CS_N=1. Reset mid-frame therefore never produces a misaligned byte.
  - IDLE: MISO_OE=0, MISO=0. On synced CS_N falling: load tx reg with Disp_Word, bit counter=0, go to ACTIVE.
  - ACTIVE: MISO_OE=1, MISO=tx[DATA_W-1].
    - Synced SCLK rising: rx <= {rx[DATA_W-2:0], MOSI}, counter+1.
    - When counter reaches DATA_W: Disp_Word <= completed byte, Set_Flag=1 for exactly one cycle, and counter wraps to 0.
    - Synced SCLK falling: if counter==0 and at least one byte has completed in this frame, tx <= Disp_Word (echo reload); otherwise tx shifts left, filling with 0.
    - Synced CS_N rising: go to IDLE. If counter!=0, pulse Frame_Err for one cycle and discard the partial byte; Disp_Word is unchanged.
- Latency: Set_Flag and the Disp_Word update occur on the same CLOCK_50 edge, SYNC_STAGES+1 cycles after the 8th SCLK rising edge at the pin.
- Multi-byte frames: the bit counter wraps with no gap. Each byte raises its own Set_Flag. MISO during byte n carries byte n-1 (byte 0 carries the pre-frame Disp_Word).
- Simultaneous events:
  - SCLK rising and CS_N rising synced in the same cycle: CS_N wins, the edge is ignored, and Frame_Err follows the counter value before that edge.
  - SCLK edges while in IDLE or WAIT_IDLE are ignored.
- Reset asserted at any time: all outputs return to reset values on the next edge, and the FSM re-enters WAIT_IDLE.

Test Plan:
- Reset, then a single frame with byte 0xA5 at 5 MHz → Disp_Word=0xA5; Set_Flag high exactly 1 cycle, 3 cycles after the 8th SCLK rise; MISO shifts out 0x00.
- One frame with bytes 0x3C, 0xF0, 0x81 → three Set_Flag pulses; Disp_Word ends at 0x81; MISO bytes are 0xA5 (previous), 0x3C, 0xF0.
- CS_N deasserted after 5 bits of 0xFF → Frame_Err 1-cycle pulse; no Set_Flag; Disp_Word holds its prior value; the next full byte 0x12 is received correctly.
- Reset asserted mid-byte with CS_N still low and SCLK toggling → outputs reset; no Set_Flag until CS_N goes high then low; the next byte 0x5A lands intact.
- SCLK toggling with CS_N high → no Set_Flag, MISO_OE=0, Disp_Word unchanged.
- Back-to-back frames with a CS_N high gap of 4 CLOCK_50 cycles, bytes 0x00 then 0xFF → both are captured and each gets its own Set_Flag.
